inst_fetch: RTL and testbench

//  Instruction fetch stage feeding the CPU decode stage.
//  - Holds the PC and drives a 1-cycle synchronous-read port into the instruction cache.
//  - Buffers fetched words in a small FIFO and hands them downstream on a valid/ready handshake.
//  - Redirects on taken branches.
//  - Stops fetching on the halt word 32'hFFFF_FFFF and raises is_halt_N low once drained.

---
 rtl/inst_fetch.sv | 133 +++++++++++++
 tb/tb_inst_fetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: PC + 1-cycle imem read, DEPTH-entry output buffer, branch redirect, halt on HALT_WORD.
// Issue to if_valid is 2 cycles; issue stalls when buffered + in-flight words would exceed DEPTH.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 10,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_inst,
    output logic [31:0]        if_pc,
    output logic               is_halt_N,
    output logic [31:0]        fetch_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_cnt_q, fetch_cnt_d;

    logic          redirect, pop, push, issue, resp_live, resp_halt;
    logic [CW:0]   occupancy;
    logic          unused_target_bits;

    assign unused_target_bits = ^br_target[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        redirect  = br_taken && (state_q != S_HALTED);
        if_valid  = (count_q != '0) && (state_q != S_HALTED);
        pop       = if_valid && if_ready;
        // Slot accounting counts the word returning this cycle and frees the one leaving.
        occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue     = !RESET && (state_q == S_RUN) && !br_taken && (occupancy < (CW+1)'(DEPTH));
        resp_live = inflight_q && !redirect && (state_q == S_RUN);
        resp_halt = resp_live && (imem_rdata == HALT_WORD);
        push      = resp_live && !resp_halt;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fetch_cnt_d   = fetch_cnt_q + 32'(pop);
        if (redirect) begin
            // The in-flight word returns this same cycle and is simply not pushed.
            pc_d     = {br_target[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = S_RUN;
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            case (state_q)
                S_RUN:   if (resp_halt) state_d = S_DRAIN;
                S_DRAIN: if (count_q == '0) state_d = S_HALTED;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetch_cnt_q   <= fetch_cnt_d;
            if (push) begin
                inst_mem_q[wr_ptr_q] <= imem_rdata;
                pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
            end
        end
    end

    assign imem_en   = issue;
    assign imem_addr = pc_q[IMEM_AW+1:2];
    assign if_inst   = inst_mem_q[rd_ptr_q];
    assign if_pc     = pc_mem_q[rd_ptr_q];
    assign is_halt_N = (state_q != S_HALTED);
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: imem model, scoreboard of expected accepted (pc, inst) pairs, directed runs.
module tb_inst_fetch;

    logic        CLOCK_50 = 1'b0;
    logic        RESET    = 1'b1;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        br_taken   = 1'b0;
    logic [31:0] br_target  = '0;
    logic        if_valid;
    logic        if_ready   = 1'b1;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        is_halt_N;
    logic [31:0] fetch_cnt;

    inst_fetch dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .imem_en   (imem_en),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .br_taken  (br_taken),
        .br_target (br_target),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_inst   (if_inst),
        .if_pc     (if_pc),
        .is_halt_N (is_halt_N),
        .fetch_cnt (fetch_cnt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [31:0] mem [1024];

    always @(posedge CLOCK_50) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          halt_cyc = 0;
    logic [31:0] last_pc = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_range(input logic [31:0] lo, input logic [31:0] hi);
        for (logic [31:0] a = lo; a <= hi; a += 32'd4) begin
            sb_q.push_back('{pc: a, inst: mem[a[11:2]]});
        end
    endtask

    task automatic wait_head(input logic [31:0] pc);
        int n;
        n = 0;
        while (!(if_valid && if_pc == pc) && n < 200) begin
            step();
            n++;
        end
        check_eq("wait_head", if_pc, pc);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc);
        int n;
        n = 0;
        while (!if_valid && n < 20) begin
            step();
            n++;
        end
        check_eq(tag, if_pc, pc);
    endtask

    task automatic wait_halt(input logic [31:0] exp_cnt);
        int n;
        n = 0;
        while (is_halt_N && n < 300) begin
            step();
            n++;
        end
        check_eq("halt_reached", 32'(is_halt_N), 32'd0);
        @(negedge CLOCK_50);
        #1;
        check_eq("halt_latency", halt_cyc - last_acc_cyc, 32'd2);
        check_eq("last_pc", last_pc, 32'h4C);
        check_eq("fetch_cnt", fetch_cnt, exp_cnt);
        check_eq("sb_drained", sb_q.size(), 32'd0);
        repeat (2) begin
            step();
            check_eq("halted_imem_en", 32'(imem_en), 32'd0);
            check_eq("halted_vld", 32'(if_valid), 32'd0);
        end
    endtask

    // Output monitor: scoreboard pops, hold-under-backpressure and halt timing.
    initial begin
        exp_t        e;
        logic        prev_stall;
        logic        prev_halt_n;
        logic [31:0] prev_pc, prev_inst;
        int          stall_n;
        prev_stall  = 1'b0;
        prev_halt_n = 1'b1;
        prev_pc     = '0;
        prev_inst   = '0;
        stall_n     = 0;
        forever begin
            @(negedge CLOCK_50);
            cyc++;
            if (RESET) begin
                prev_stall  = 1'b0;
                prev_halt_n = 1'b1;
                stall_n     = 0;
            end else begin
                if (prev_stall) begin
                    check_eq("hold_vld", 32'(if_valid), 32'd1);
                    check_eq("hold_pc", if_pc, prev_pc);
                    check_eq("hold_inst", if_inst, prev_inst);
                end
                stall_n = (if_valid && !if_ready) ? stall_n + 1 : 0;
                if (stall_n >= 2) check_eq("full_no_issue", 32'(imem_en), 32'd0);
                if (if_valid && if_ready) begin
                    if (sb_q.size() == 0) begin
                        check_eq("sb_underflow", if_pc, 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("acc_pc", if_pc, e.pc);
                        check_eq("acc_inst", if_inst, e.inst);
                    end
                    last_pc      = if_pc;
                    last_acc_cyc = cyc;
                end
                if (prev_halt_n && !is_halt_N) halt_cyc = cyc;
                prev_halt_n = is_halt_N;
                prev_stall  = if_valid && !if_ready && !br_taken;
                prev_pc     = if_pc;
                prev_inst   = if_inst;
            end
        end
    end

    initial begin
        int lat;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        for (int i = 4; i <= 18; i++) mem[i] = 32'h0000_0033 | (32'(i) << 7);
        mem[19] = 32'h0010_0093;
        mem[20] = 32'hFFFF_FFFF;

        // Power-on reset values
        step();
        step();
        check_eq("rst_imem_en", 32'(imem_en), 32'd0);
        check_eq("rst_vld", 32'(if_valid), 32'd0);
        check_eq("rst_inst", if_inst, 32'd0);
        check_eq("rst_pc", if_pc, 32'd0);
        check_eq("rst_halt_n", 32'(is_halt_N), 32'd1);
        check_eq("rst_cnt", fetch_cnt, 32'd0);

        // Sequential fetch with a 5-cycle backpressure window, then halt
        push_range(32'h0, 32'h4C);
        RESET = 1'b0;
        #1;
        check_eq("first_issue_en", 32'(imem_en), 32'd1);
        check_eq("first_issue_addr", 32'(imem_addr), 32'd0);
        lat = 0;
        while (!if_valid && lat < 10) begin
            step();
            lat++;
        end
        check_eq("first_latency", lat, 32'd2);
        check_eq("first_pc", if_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("stream_vld", 32'(if_valid), 32'd1);
        end
        wait_head(32'h20);
        if_ready = 1'b0;
        repeat (5) step();
        if_ready = 1'b1;
        wait_halt(32'd20);

        // Halt cancelled by a redirect while draining; redirect ignored once halted
        RESET = 1'b1;
        step();
        sb_q.delete();
        push_range(32'h0, 32'h48);
        RESET = 1'b0;
        wait_head(32'h48);
        step();
        check_eq("drain_head", if_pc, 32'h4C);
        if_ready = 1'b0;
        step();
        check_eq("drain_no_issue", 32'(imem_en), 32'd0);
        check_eq("drain_halt_n", 32'(is_halt_N), 32'd1);
        check_eq("drain_vld", 32'(if_valid), 32'd1);
        step();
        br_taken  = 1'b1;
        br_target = 32'h10;
        push_range(32'h10, 32'h4C);
        step();
        br_taken = 1'b0;
        if_ready = 1'b1;
        #1;
        check_eq("cancel_flush", 32'(if_valid), 32'd0);
        check_eq("cancel_halt_n", 32'(is_halt_N), 32'd1);
        check_eq("cancel_issue", 32'(imem_en), 32'd1);
        check_eq("cancel_addr", 32'(imem_addr), 32'd4);
        wait_valid("cancel_first", 32'h10);
        wait_halt(32'd35);
        br_taken  = 1'b1;
        br_target = 32'h10;
        step();
        br_taken = 1'b0;
        check_eq("halted_br_halt_n", 32'(is_halt_N), 32'd0);
        step();
        check_eq("halted_br_imem_en", 32'(imem_en), 32'd0);
        check_eq("halted_br_vld", 32'(if_valid), 32'd0);
        check_eq("halted_br_cnt", fetch_cnt, 32'd35);

        // Redirects with a simultaneous accept, aligned and unaligned targets
        RESET = 1'b1;
        step();
        sb_q.delete();
        push_range(32'h0, 32'h1C);
        RESET = 1'b0;
        wait_head(32'h1C);
        br_taken  = 1'b1;
        br_target = 32'h10;
        push_range(32'h10, 32'h30);
        step();
        br_taken = 1'b0;
        check_eq("redir_flush", 32'(if_valid), 32'd0);
        wait_valid("redir_first", 32'h10);
        wait_head(32'h30);
        br_taken  = 1'b1;
        br_target = 32'h13;
        push_range(32'h10, 32'h4C);
        step();
        br_taken = 1'b0;
        check_eq("redir2_flush", 32'(if_valid), 32'd0);
        wait_valid("redir2_first", 32'h10);
        wait_halt(32'd33);

        // Reset mid-stream with a word buffered and a read in flight
        RESET = 1'b1;
        step();
        sb_q.delete();
        push_range(32'h0, 32'h1C);
        RESET = 1'b0;
        wait_head(32'h18);
        RESET    = 1'b1;
        if_ready = 1'b0;
        sb_q.delete();
        step();
        RESET    = 1'b0;
        if_ready = 1'b1;
        #1;
        check_eq("mid_rst_vld", 32'(if_valid), 32'd0);
        check_eq("mid_rst_inst", if_inst, 32'd0);
        check_eq("mid_rst_pc", if_pc, 32'd0);
        check_eq("mid_rst_halt_n", 32'(is_halt_N), 32'd1);
        check_eq("mid_rst_cnt", fetch_cnt, 32'd0);
        check_eq("mid_rst_addr", 32'(imem_addr), 32'd0);
        push_range(32'h0, 32'h4C);
        wait_valid("mid_rst_first", 32'h0);
        wait_halt(32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
